wb_port_arbiter: RTL

Shares the register file's two writeback ports (A and B) among three result producers: exec port A, exec port B and the load/store unit. It sits between the exec/LSU result outputs and the register controller's writeback inputs (`wbA_i`/`wbB_i`, address, value, status). Each requester has a one-entry holding register. Up to two holds drain per cycle, with rotating priority and same-address conflict protection.

---
 rtl/wb_pkg.sv | 24 ++
 rtl/wb_rr_picker.sv | 71 +++++++
 rtl/wb_port_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback port arbiter: requester indices,
// default widths, the holding-entry layout and a modulo-3 pointer step.
package wb_pkg;

   localparam int WB_DATA_W = 16;
   localparam int WB_ADDR_W = 5;
   localparam int NUM_REQ   = 3;

   localparam logic [1:0] REQ_EXECA = 2'd0;
   localparam logic [1:0] REQ_EXECB = 2'd1;
   localparam logic [1:0] REQ_LSU   = 2'd2;

   typedef struct packed {
      logic [WB_ADDR_W-1:0] addr;
      logic [WB_DATA_W-1:0] data;
      logic [1:0]           status;
   } wb_entry_t;

   // Next requester index in rotation order 0 -> 1 -> 2 -> 0.
   function automatic logic [1:0] rr_inc(input logic [1:0] idx);
      return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
   endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Combinational rotating-priority picker: first pending hold from the pointer
// goes to port A, the next one to port B unless it targets the same register.
module wb_rr_picker
   import wb_pkg::*;
#(
   parameter int ADDR_W = WB_ADDR_W
)(
   input  logic [NUM_REQ-1:0]        i_pending,
   input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
   input  logic [1:0]                i_rr,
   output logic [1:0]                o_w1Idx,
   output logic                      o_w1Vld,
   output logic [1:0]                o_w2Idx,
   output logic                      o_w2Vld,
   output logic [NUM_REQ-1:0]        o_grant
);

   logic [1:0]        w_scanIdx;
   logic [1:0]        w_w1Idx;
   logic              w_w1Found;
   logic [1:0]        w_w2Idx;
   logic              w_w2Found;
   logic [ADDR_W-1:0] w_w1Addr;
   logic [ADDR_W-1:0] w_w2Addr;

   // Scan the three requesters starting at the pointer; a W2 that collides with W1's address sits out.
   always_comb begin
      w_scanIdx = i_rr;
      w_w1Idx   = 2'd0;
      w_w1Found = 1'b0;
      w_w2Idx   = 2'd0;
      w_w2Found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (i_pending[w_scanIdx]) begin
            if (!w_w1Found) begin
               w_w1Found = 1'b1;
               w_w1Idx   = w_scanIdx;
            end else if (!w_w2Found) begin
               w_w2Found = 1'b1;
               w_w2Idx   = w_scanIdx;
            end else begin
               w_w2Found = w_w2Found;
            end
         end else begin
            w_w1Found = w_w1Found;
         end
         w_scanIdx = rr_inc(w_scanIdx);
      end

      w_w1Addr = i_addr[w_w1Idx*ADDR_W +: ADDR_W];
      w_w2Addr = i_addr[w_w2Idx*ADDR_W +: ADDR_W];

      o_w1Idx = w_w1Idx;
      o_w1Vld = w_w1Found;
      o_w2Idx = w_w2Idx;
      o_w2Vld = w_w2Found && (w_w2Addr != w_w1Addr);

      o_grant = 3'b000;
      if (o_w1Vld) begin
         o_grant = o_grant | (3'b001 << w_w1Idx);
      end else begin
         o_grant = o_grant;
      end
      if (o_w2Vld) begin
         o_grant = o_grant | (3'b001 << w_w2Idx);
      end else begin
         o_grant = o_grant;
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares two register-file writeback ports among execA, execB and the LSU,
// each buffered by a one-entry hold; writes appear registered one cycle after grant.
module wb_port_arbiter
   import wb_pkg::*;
#(
   parameter int DATA_W = WB_DATA_W,
   parameter int ADDR_W = WB_ADDR_W
)(
   input  logic                      clock_i,
   input  logic                      reset_i,
   input  logic [2:0]                reqValid_i,
   output logic [2:0]                reqReady_o,
   input  logic [3*ADDR_W-1:0]       reqAddr_i,
   input  logic [3*DATA_W-1:0]       reqData_i,
   input  logic [5:0]                reqStatus_i,
   output logic                      wbA_o,
   output logic                      wbB_o,
   output logic [ADDR_W-1:0]         wbAddrA_o,
   output logic [ADDR_W-1:0]         wbAddrB_o,
   output logic [DATA_W-1:0]         wbValA_o,
   output logic [DATA_W-1:0]         wbValB_o,
   output logic [1:0]                operationStatusA_o,
   output logic [1:0]                operationStatusB_o,
   output logic [2:0]                pending_o
);

   logic [NUM_REQ-1:0]        r_pending;
   logic [ADDR_W-1:0]         r_holdAddr   [NUM_REQ];
   logic [DATA_W-1:0]         r_holdData   [NUM_REQ];
   logic [1:0]                r_holdStatus [NUM_REQ];
   logic [1:0]                r_rr;

   logic                      r_wbA;
   logic                      r_wbB;
   logic [ADDR_W-1:0]         r_wbAddrA;
   logic [ADDR_W-1:0]         r_wbAddrB;
   logic [DATA_W-1:0]         r_wbValA;
   logic [DATA_W-1:0]         r_wbValB;
   logic [1:0]                r_statusA;
   logic [1:0]                r_statusB;

   logic [NUM_REQ*ADDR_W-1:0] w_holdAddrPacked;
   logic [1:0]                w_w1Idx;
   logic                      w_w1Vld;
   logic [1:0]                w_w2Idx;
   logic                      w_w2Vld;
   logic [NUM_REQ-1:0]        w_grant;
   logic [2:0]                w_ready;

   // Flatten hold addresses for the picker's conflict check.
   always_comb begin
      w_holdAddrPacked = {(NUM_REQ*ADDR_W){1'b0}};
      for (int r = 0; r < NUM_REQ; r++) begin
         w_holdAddrPacked[r*ADDR_W +: ADDR_W] = r_holdAddr[r];
      end
   end

   wb_rr_picker #(
      .ADDR_W (ADDR_W)
   ) u_picker (
      .i_pending (r_pending),
      .i_addr    (w_holdAddrPacked),
      .i_rr      (r_rr),
      .o_w1Idx   (w_w1Idx),
      .o_w1Vld   (w_w1Vld),
      .o_w2Idx   (w_w2Idx),
      .o_w2Vld   (w_w2Vld),
      .o_grant   (w_grant)
   );

   // A hold being drained this cycle can be refilled at the same edge.
   assign w_ready    = ~r_pending | w_grant;
   assign reqReady_o = w_ready;

   // Holding registers: capture on acceptance, release when granted without refill.
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         r_pending <= 3'b000;
         for (int r = 0; r < NUM_REQ; r++) begin
            r_holdAddr[r]   <= {ADDR_W{1'b0}};
            r_holdData[r]   <= {DATA_W{1'b0}};
            r_holdStatus[r] <= 2'b00;
         end
      end else begin
         for (int r = 0; r < NUM_REQ; r++) begin
            if (reqValid_i[r] && w_ready[r]) begin
               r_pending[r]    <= 1'b1;
               r_holdAddr[r]   <= reqAddr_i[r*ADDR_W +: ADDR_W];
               r_holdData[r]   <= reqData_i[r*DATA_W +: DATA_W];
               r_holdStatus[r] <= (r == int'(REQ_LSU)) ? 2'b00 : reqStatus_i[2*r +: 2];
            end else if (w_grant[r]) begin
               r_pending[r]    <= 1'b0;
            end else begin
               r_pending[r]    <= r_pending[r];
            end
         end
      end
   end

   // Rotating pointer moves past the last requester granted this cycle.
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         r_rr <= 2'd0;
      end else if (w_w2Vld) begin
         r_rr <= rr_inc(w_w2Idx);
      end else if (w_w1Vld) begin
         r_rr <= rr_inc(w_w1Idx);
      end else begin
         r_rr <= r_rr;
      end
   end

   // Registered writeback ports; an idle port drives all fields to zero.
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         r_wbA     <= 1'b0;
         r_wbAddrA <= {ADDR_W{1'b0}};
         r_wbValA  <= {DATA_W{1'b0}};
         r_statusA <= 2'b00;
         r_wbB     <= 1'b0;
         r_wbAddrB <= {ADDR_W{1'b0}};
         r_wbValB  <= {DATA_W{1'b0}};
         r_statusB <= 2'b00;
      end else begin
         r_wbA <= w_w1Vld;
         if (w_w1Vld) begin
            r_wbAddrA <= r_holdAddr[w_w1Idx];
            r_wbValA  <= r_holdData[w_w1Idx];
            r_statusA <= r_holdStatus[w_w1Idx];
         end else begin
            r_wbAddrA <= {ADDR_W{1'b0}};
            r_wbValA  <= {DATA_W{1'b0}};
            r_statusA <= 2'b00;
         end
         r_wbB <= w_w2Vld;
         if (w_w2Vld) begin
            r_wbAddrB <= r_holdAddr[w_w2Idx];
            r_wbValB  <= r_holdData[w_w2Idx];
            r_statusB <= r_holdStatus[w_w2Idx];
         end else begin
            r_wbAddrB <= {ADDR_W{1'b0}};
            r_wbValB  <= {DATA_W{1'b0}};
            r_statusB <= 2'b00;
         end
      end
   end

   assign wbA_o              = r_wbA;
   assign wbAddrA_o          = r_wbAddrA;
   assign wbValA_o           = r_wbValA;
   assign operationStatusA_o = r_statusA;
   assign wbB_o              = r_wbB;
   assign wbAddrB_o          = r_wbAddrB;
   assign wbValB_o           = r_wbValB;
   assign operationStatusB_o = r_statusB;
   assign pending_o          = r_pending;

endmodule
